seg7_scan_ctrl: RTL and testbench

SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

---
 rtl/seg7_pkg.sv | 26 ++
 rtl/seg7_hex_dec.sv | 32 +++
 rtl/seg7_scan_ctrl.sv | 173 +++++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared types and hex glyph table for the multiplexed 7-segment scan controller.
// Glyph bit 0 is segment a through bit 6 is segment g, active-high.
package seg7_pkg;

   typedef logic [3:0] nibble_t;
   typedef logic [6:0] glyph_t;

   localparam glyph_t Glyph0     = 7'h3F;
   localparam glyph_t Glyph1     = 7'h06;
   localparam glyph_t Glyph2     = 7'h5B;
   localparam glyph_t Glyph3     = 7'h4F;
   localparam glyph_t Glyph4     = 7'h66;
   localparam glyph_t Glyph5     = 7'h6D;
   localparam glyph_t Glyph6     = 7'h7D;
   localparam glyph_t Glyph7     = 7'h07;
   localparam glyph_t Glyph8     = 7'h7F;
   localparam glyph_t Glyph9     = 7'h6F;
   localparam glyph_t GlyphA     = 7'h77;
   localparam glyph_t GlyphB     = 7'h7C;
   localparam glyph_t GlyphC     = 7'h39;
   localparam glyph_t GlyphD     = 7'h5E;
   localparam glyph_t GlyphE     = 7'h79;
   localparam glyph_t GlyphF     = 7'h71;
   localparam glyph_t GlyphBlank = 7'h00;

endpackage

// File: rtl/seg7_hex_dec.sv
// Combinational nibble-to-glyph decoder; output is active-high, polarity is
// applied by the caller after blanking.
module seg7_hex_dec
   import seg7_pkg::*;
(
   input  nibble_t nibble_i,
   output glyph_t  glyph_o
);

   always_comb begin
      glyph_o = GlyphBlank;
      unique case (nibble_i)
         4'h0: glyph_o = Glyph0;
         4'h1: glyph_o = Glyph1;
         4'h2: glyph_o = Glyph2;
         4'h3: glyph_o = Glyph3;
         4'h4: glyph_o = Glyph4;
         4'h5: glyph_o = Glyph5;
         4'h6: glyph_o = Glyph6;
         4'h7: glyph_o = Glyph7;
         4'h8: glyph_o = Glyph8;
         4'h9: glyph_o = Glyph9;
         4'hA: glyph_o = GlyphA;
         4'hB: glyph_o = GlyphB;
         4'hC: glyph_o = GlyphC;
         4'hD: glyph_o = GlyphD;
         4'hE: glyph_o = GlyphE;
         4'hF: glyph_o = GlyphF;
      endcase
   end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scan controller with frame-synchronous update handshake and
// PWM brightness. Define SEG7_LZB_EN to enable leading-zero blanking.
module seg7_scan_ctrl
   import seg7_pkg::*;
#(
   parameter int unsigned DIS_NUM     = 4,
   parameter int unsigned MLT_CNT     = 10,
   parameter int unsigned BRIGHT_W    = 3,
   parameter bit          SEG_ACT_LOW = 1'b0,
   parameter bit          SEL_ACT_LOW = 1'b0
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [DIS_NUM*4-1:0]  i_bcd_data,
   input  logic [DIS_NUM-1:0]    i_dp,
   input  logic [BRIGHT_W-1:0]   i_bright,
   input  logic                  i_load,
   output logic                  o_ready,
   output logic [6:0]            o_segments,
   output logic                  o_dp,
   output logic [DIS_NUM-1:0]    o_segments_sel,
   output logic                  o_frame_done
);

   localparam int unsigned SlotW = $clog2(MLT_CNT);
   localparam int unsigned DigW  = (DIS_NUM > 1) ? $clog2(DIS_NUM) : 1;

   localparam logic [SlotW-1:0]   SlotLast = SlotW'(MLT_CNT - 1);
   localparam logic [DigW-1:0]    DigLast  = DigW'(DIS_NUM - 1);
   localparam glyph_t             SegIdle  = {7{SEG_ACT_LOW}};
   localparam logic [DIS_NUM-1:0] SelIdle  = {DIS_NUM{SEL_ACT_LOW}};

   logic [SlotW-1:0]     slot_q;
   logic [DigW-1:0]      digit_q;
   logic [BRIGHT_W-1:0]  pwm_q;

   logic [DIS_NUM*4-1:0] data_act_q, data_shd_q;
   logic [DIS_NUM-1:0]   dp_act_q, dp_shd_q;
   logic [BRIGHT_W-1:0]  bright_act_q, bright_shd_q;
   logic                 pending_q;

   glyph_t               seg_q;
   logic                 dp_q;
   logic [DIS_NUM-1:0]   sel_q;
   logic                 frame_done_q;

   logic                 slot_wrap;
   logic                 frame_end;
   logic                 capture;

   assign slot_wrap = (slot_q == SlotLast);
   assign frame_end = slot_wrap && (digit_q == DigLast);
   assign capture   = i_load && !pending_q;

   // Scan timing: slot counter, digit index and free-running PWM counter
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         slot_q  <= '0;
         digit_q <= '0;
         pwm_q   <= '0;
      end else begin
         pwm_q <= pwm_q + 1'b1;
         if (slot_wrap) begin
            slot_q  <= '0;
            digit_q <= (digit_q == DigLast) ? '0 : digit_q + 1'b1;
         end else begin
            slot_q <= slot_q + 1'b1;
         end
      end
   end

   // Capture needs !pending and copy needs pending, so the two never collide; a
   // capture on the frame-end cycle simply waits for the next boundary.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         pending_q    <= 1'b0;
         data_shd_q   <= '0;
         dp_shd_q     <= '0;
         bright_shd_q <= '1;
         data_act_q   <= '0;
         dp_act_q     <= '0;
         bright_act_q <= '1;
      end else if (frame_end && pending_q) begin
         data_act_q   <= data_shd_q;
         dp_act_q     <= dp_shd_q;
         bright_act_q <= bright_shd_q;
         pending_q    <= 1'b0;
      end else if (capture) begin
         data_shd_q   <= i_bcd_data;
         dp_shd_q     <= i_dp;
         bright_shd_q <= i_bright;
         pending_q    <= 1'b1;
      end
   end

   nibble_t            cur_nib;
   logic               cur_dp;
   logic [DIS_NUM-1:0] sel_oh;
   logic               lit;
   glyph_t             dec_glyph;

   always_comb begin
      cur_nib = '0;
      cur_dp  = 1'b0;
      sel_oh  = '0;
      for (int k = 0; k < int'(DIS_NUM); k++) begin
         if (digit_q == DigW'(k)) begin
            cur_nib   = data_act_q[k*4 +: 4];
            cur_dp    = dp_act_q[k];
            sel_oh[k] = 1'b1;
         end
      end
   end

   // All-ones brightness is always on; otherwise lit for the first `bright` PWM steps
   assign lit = (&bright_act_q) || (pwm_q < bright_act_q);

   seg7_hex_dec u_hex_dec (
      .nibble_i (cur_nib),
      .glyph_o  (dec_glyph)
   );

`ifdef SEG7_LZB_EN
   logic [DIS_NUM-1:0] lead_zero;
   logic               lz_run;

   // lead_zero[k]: nibble k and all above are zero with no dp set; digit 0 stays lit
   always_comb begin
      lead_zero = '0;
      lz_run    = 1'b1;
      for (int k = int'(DIS_NUM) - 1; k >= 1; k--) begin
         lz_run       = lz_run && (data_act_q[k*4 +: 4] == 4'h0) && !dp_act_q[k];
         lead_zero[k] = lz_run;
      end
   end
`endif

   glyph_t             seg_d;
   logic               dp_d;
   logic [DIS_NUM-1:0] sel_d;

   always_comb begin
      seg_d = lit ? dec_glyph : GlyphBlank;
      dp_d  = lit && cur_dp;
      sel_d = lit ? sel_oh : '0;
`ifdef SEG7_LZB_EN
      if (|(lead_zero & sel_oh)) begin
         seg_d = GlyphBlank;
      end
`endif
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         seg_q        <= SegIdle;
         dp_q         <= SEG_ACT_LOW;
         sel_q        <= SelIdle;
         frame_done_q <= 1'b0;
      end else begin
         seg_q        <= seg_d ^ SegIdle;
         dp_q         <= dp_d ^ SEG_ACT_LOW;
         sel_q        <= sel_d ^ SelIdle;
         frame_done_q <= frame_end;
      end
   end

   assign o_ready        = !pending_q;
   assign o_segments     = seg_q;
   assign o_dp           = dp_q;
   assign o_segments_sel = sel_q;
   assign o_frame_done   = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed self-checking bench for seg7_scan_ctrl (4 digits, 10 cycles/slot, 3-bit
// brightness) plus an inverted-polarity instance; honours SEG7_LZB_EN when defined.
module tb_seg7_scan_ctrl;

`ifdef SEG7_LZB_EN
   localparam bit Lzb = 1'b1;
`else
   localparam bit Lzb = 1'b0;
`endif

   logic        clk    = 1'b0;
   logic        rst_n  = 1'b0;
   logic [15:0] bcd    = 16'h0000;
   logic [3:0]  dp     = 4'b0000;
   logic [2:0]  bright = 3'd7;
   logic        load   = 1'b0;

   logic        ready;
   logic [6:0]  seg;
   logic        seg_dp;
   logic [3:0]  sel;
   logic        fd;

   logic [15:0] bcd_inv    = 16'h0008;
   logic [3:0]  dp_inv_in  = 4'b0000;
   logic [2:0]  bright_inv = 3'd7;
   logic        load_inv   = 1'b0;
   logic        ready_inv;
   logic [6:0]  seg_inv;
   logic        dp_inv;
   logic [3:0]  sel_inv;
   logic        fd_inv;

   int checks = 0;
   int errors = 0;
   int edge_n = -1;

   always #5 clk = ~clk;

   seg7_scan_ctrl #(
      .DIS_NUM     (4),
      .MLT_CNT     (10),
      .BRIGHT_W    (3),
      .SEG_ACT_LOW (1'b0),
      .SEL_ACT_LOW (1'b0)
   ) u_dut (
      .i_clk          (clk),
      .i_rst          (rst_n),
      .i_bcd_data     (bcd),
      .i_dp           (dp),
      .i_bright       (bright),
      .i_load         (load),
      .o_ready        (ready),
      .o_segments     (seg),
      .o_dp           (seg_dp),
      .o_segments_sel (sel),
      .o_frame_done   (fd)
   );

   seg7_scan_ctrl #(
      .DIS_NUM     (4),
      .MLT_CNT     (10),
      .BRIGHT_W    (3),
      .SEG_ACT_LOW (1'b1),
      .SEL_ACT_LOW (1'b1)
   ) u_dut_inv (
      .i_clk          (clk),
      .i_rst          (rst_n),
      .i_bcd_data     (bcd_inv),
      .i_dp           (dp_inv_in),
      .i_bright       (bright_inv),
      .i_load         (load_inv),
      .o_ready        (ready_inv),
      .o_segments     (seg_inv),
      .o_dp           (dp_inv),
      .o_segments_sel (sel_inv),
      .o_frame_done   (fd_inv)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_n);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      edge_n++;
   endtask

   task automatic goto_edge(input int target);
      while (edge_n < target) step();
   endtask

   task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic [2:0] b);
      bcd    = d;
      dp     = p;
      bright = b;
      load   = 1'b1;
      step();
      load   = 1'b0;
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_sel"},       32'(sel),     32'h0);
      check({tag, "_seg"},       32'(seg),     32'h0);
      check({tag, "_dp"},        32'(seg_dp),  32'h0);
      check({tag, "_ready"},     32'(ready),   32'h1);
      check({tag, "_fd"},        32'(fd),      32'h0);
      check({tag, "_inv_sel"},   32'(sel_inv), 32'hF);
      check({tag, "_inv_seg"},   32'(seg_inv), 32'h7F);
      check({tag, "_inv_dp"},    32'(dp_inv),  32'h1);
      check({tag, "_inv_ready"}, 32'(ready_inv), 32'h1);
   endtask

   logic [6:0] glyph_789b [4] = '{7'h7C, 7'h6F, 7'h7F, 7'h07};

   initial begin
      int         lit_cnt;
      logic [3:0] exp_sel;
      logic [3:0] sel_acc;
      logic [6:0] seg_acc;

      #12;
      check_idle("rst");
      @(negedge clk);
      rst_n  = 1'b1;
      edge_n = -1;

      // Full-brightness scan over two frames; inverted instance loads an 8 mid-frame
      for (int e = 0; e < 80; e++) begin
         step();
         if (edge_n == 5) load_inv = 1'b1;
         if (edge_n == 6) load_inv = 1'b0;
         check("scan_sel", 32'(sel), 32'(4'b0001 << ((edge_n / 10) % 4)));
         check("scan_fd", 32'(fd), 32'((edge_n % 40) == 39));
         if (edge_n == 0) begin
            check("first_seg", 32'(seg), 32'h3F);
            check("inv0_seg", 32'(seg_inv), 32'h40);
            check("inv0_sel", 32'(sel_inv), 32'hE);
         end
         if (edge_n == 40) begin
            check("inv8_seg", 32'(seg_inv), 32'h00);
            check("inv8_sel", 32'(sel_inv), 32'hE);
            check("inv8_dp", 32'(dp_inv), 32'h1);
         end
      end

      // Mid-frame load of 0x12AF with dp on digit 2
      goto_edge(85);
      do_load(16'h12AF, 4'b0100, 3'd7);
      check("ld_ready_low", 32'(ready), 32'h0);
      goto_edge(100);
      check("ld_old_d2", 32'(seg), Lzb ? 32'h00 : 32'h3F);
      goto_edge(118);
      check("ld_ready_pre", 32'(ready), 32'h0);
      goto_edge(119);
      check("ld_ready_back", 32'(ready), 32'h1);
      check("ld_fd", 32'(fd), 32'h1);
      check("ld_old_d3", 32'(seg), Lzb ? 32'h00 : 32'h3F);
      goto_edge(120);
      check("ld_d0_sel", 32'(sel), 32'h1);
      check("ld_d0_seg", 32'(seg), 32'h71);
      check("ld_d0_dp", 32'(seg_dp), 32'h0);
      goto_edge(130);
      check("ld_d1_seg", 32'(seg), 32'h77);
      goto_edge(140);
      check("ld_d2_seg", 32'(seg), 32'h5B);
      check("ld_d2_dp", 32'(seg_dp), 32'h1);
      goto_edge(150);
      check("ld_d3_seg", 32'(seg), 32'h06);
      check("ld_d3_dp", 32'(seg_dp), 32'h0);

      // i_load held high: one capture per boundary, later data does not overwrite
      goto_edge(160);
      bcd  = 16'h3456;
      dp   = 4'b0000;
      load = 1'b1;
      step();
      check("hold_ready_low", 32'(ready), 32'h0);
      bcd = 16'h789B;
      goto_edge(199);
      check("hold_ready_back", 32'(ready), 32'h1);
      step();
      load = 1'b0;
      check("hold_recapture", 32'(ready), 32'h0);
      check("hold_d0", 32'(seg), 32'h7D);
      goto_edge(210);
      check("hold_d1", 32'(seg), 32'h6D);
      goto_edge(230);
      check("hold_d3", 32'(seg), 32'h4F);
      goto_edge(239);
      check("hold_ready2", 32'(ready), 32'h1);
      goto_edge(240);
      check("hold_second_d0", 32'(seg), 32'h7C);

      // Brightness 3: lit while PWM (edge mod 8) < 3
      goto_edge(245);
      do_load(16'h789B, 4'b0000, 3'd3);
      goto_edge(279);
      lit_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         exp_sel = ((edge_n % 8) < 3) ? (4'b0001 << ((edge_n / 10) % 4)) : 4'b0000;
         check("pwm_sel", 32'(sel), 32'(exp_sel));
         check("pwm_seg", 32'(seg),
               ((edge_n % 8) < 3) ? 32'(glyph_789b[(edge_n / 10) % 4]) : 32'h0);
         if (sel != 4'b0000) lit_cnt++;
      end
      check("pwm_lit_count", 32'(lit_cnt), 32'd15);

      // Brightness 0: dark
      do_load(16'h789B, 4'b0000, 3'd0);
      goto_edge(359);
      sel_acc = '0;
      seg_acc = '0;
      for (int i = 0; i < 40; i++) begin
         step();
         sel_acc |= sel;
         seg_acc |= seg;
      end
      check("dark_sel", 32'(sel_acc), 32'h0);
      check("dark_seg", 32'(seg_acc), 32'h0);

      // Leading zeros: 0x0030
      do_load(16'h0030, 4'b0000, 3'd7);
      goto_edge(440);
      check("lz_d0", 32'(seg), 32'h3F);
      goto_edge(450);
      check("lz_d1", 32'(seg), 32'h4F);
      goto_edge(460);
      check("lz_d2_sel", 32'(sel), 32'h4);
      check("lz_d2", 32'(seg), Lzb ? 32'h00 : 32'h3F);
      goto_edge(470);
      check("lz_d3_sel", 32'(sel), 32'h8);
      check("lz_d3", 32'(seg), Lzb ? 32'h00 : 32'h3F);

      // Capture on the boundary cycle waits for the following boundary
      goto_edge(478);
      do_load(16'h0000, 4'b0100, 3'd7);
      check("bnd_fd", 32'(fd), 32'h1);
      check("bnd_ready_low", 32'(ready), 32'h0);
      goto_edge(500);
      check("bnd_old_dp", 32'(seg_dp), 32'h0);
      check("bnd_old_d2", 32'(seg), Lzb ? 32'h00 : 32'h3F);
      goto_edge(518);
      check("bnd_ready_pre", 32'(ready), 32'h0);
      goto_edge(519);
      check("bnd_ready_back", 32'(ready), 32'h1);
      goto_edge(530);
      check("z_d1", 32'(seg), 32'h3F);
      goto_edge(540);
      check("z_d2", 32'(seg), 32'h3F);
      check("z_d2_dp", 32'(seg_dp), 32'h1);
      goto_edge(550);
      check("z_d3", 32'(seg), Lzb ? 32'h00 : 32'h3F);
      check("z_d3_dp", 32'(seg_dp), 32'h0);

      // Asynchronous reset mid-frame discards a pending update
      goto_edge(555);
      do_load(16'hFFFF, 4'b1111, 3'd7);
      check("prerst_ready", 32'(ready), 32'h0);
      #2;
      rst_n = 1'b0;
      #1;
      check_idle("midrst");
      @(negedge clk);
      rst_n  = 1'b1;
      edge_n = -1;
      step();
      check("post_sel", 32'(sel), 32'h1);
      check("post_seg", 32'(seg), 32'h3F);
      check("post_ready", 32'(ready), 32'h1);
      goto_edge(40);
      check("post_discard_seg", 32'(seg), 32'h3F);
      check("post_discard_dp", 32'(seg_dp), 32'h0);
      check("post_ready2", 32'(ready), 32'h1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "simulation timed out");
   end

endmodule
